// File: rtl/fpga_link_transmitter_if.sv
// Board-to-board link pins of the FPGA link transmitter.
//
// Handshake: 4-phase send/acknowledge. The master presents data_lanes and
// finish, holds them stable, then raises send. The slave raises acknowledge
// once it has taken the beat. The master then drops send, and the slave drops
// acknowledge. data_lanes and finish only change while both send and
// acknowledge are low. acknowledge is asynchronous to the master's clock.
interface fpga_link_transmitter_if #(
    parameter int LANES = 1
);
    logic             send;
    logic [LANES-1:0] data_lanes;
    logic             finish;
    logic             acknowledge;

    modport master (
        output send,
        output data_lanes,
        output finish,
        input  acknowledge
    );

    modport slave (
        input  send,
        input  data_lanes,
        input  finish,
        output acknowledge
    );
endinterface

// File: rtl/fpga_link_transmitter.sv
// FPGA-to-FPGA transmitter: sends one WIDTH-bit word as WIDTH/LANES beats,
// one 4-phase send/acknowledge handshake per beat, with selectable slice
// order, an acknowledge synchroniser and a per-phase timeout that aborts.
// WIDTH must be a multiple of LANES.
module fpga_link_transmitter #(
    parameter int WIDTH       = 8,
    parameter int LANES       = 1,
    parameter bit MSB_FIRST   = 1'b0,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     tx_data,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    // Debug view of the FSM: 0 = IDLE, 1 = SETUP, 2 = REQ, 3 = REL.
    output logic [1:0]           dbg_state,
    fpga_link_transmitter_if.master link
);
    localparam int BEATS = WIDTH / LANES;
    localparam int BW    = $clog2(BEATS) + 1;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Fewer than two stages would leave acknowledge metastability exposed.
    localparam int SS    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TW-1:0] TIMER_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        REQ   = 2'd2,
        REL   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [SS-1:0]    ack_sync_q, ack_sync_d;
    logic             send_q, send_d;
    logic             finish_q, finish_d;
    logic [LANES-1:0] data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             ack_s;
    logic             timed_out;
    logic [BW-1:0]    next_beat;
    logic [TW-1:0]    timer_inc;

    // Beat k carries slice k counted from the LSB end, or from the MSB end.
    function automatic logic [LANES-1:0] slice(input logic [WIDTH-1:0] w,
                                               input logic [BW-1:0]    k);
        int               idx;
        logic [WIDTH-1:0] shifted;
        idx     = MSB_FIRST ? (BEATS - 1 - int'(k)) : int'(k);
        shifted = w >> (idx * LANES);
        return shifted[LANES-1:0];
    endfunction

    assign ack_s      = ack_sync_q[SS-1];
    assign ack_sync_d = {ack_sync_q[SS-2:0], link.acknowledge};
    assign timed_out  = (TIMEOUT > 0) && (timer_q == TIMER_LAST);

    // Next-state and output logic; an expiring timer loses to a met exit condition.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        beat_d    = beat_q;
        timer_d   = timer_q;
        send_d    = send_q;
        finish_d  = finish_q;
        data_d    = data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        next_beat = beat_q + 1'b1;
        timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;

        case (state_q)
            IDLE: begin
                // A start coinciding with the done/error pulse is dropped.
                if (start && !done_q && !error_q) begin
                    word_d   = tx_data;
                    beat_d   = '0;
                    data_d   = slice(tx_data, '0);
                    finish_d = (BEATS == 1);
                    busy_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                send_d  = 1'b1;
                timer_d = '0;
                state_d = REQ;
            end
            REQ: begin
                if (ack_s) begin
                    send_d  = 1'b0;
                    timer_d = '0;
                    state_d = REL;
                end else if (timed_out) begin
                    send_d   = 1'b0;
                    finish_d = 1'b0;
                    data_d   = '0;
                    busy_d   = 1'b0;
                    error_d  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end
            REL: begin
                if (!ack_s) begin
                    if (beat_q == LAST_BEAT) begin
                        finish_d = 1'b0;
                        data_d   = '0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        beat_d   = next_beat;
                        data_d   = slice(word_q, next_beat);
                        finish_d = (next_beat == LAST_BEAT);
                        state_d  = SETUP;
                    end
                end else if (timed_out) begin
                    send_d   = 1'b0;
                    finish_d = 1'b0;
                    data_d   = '0;
                    busy_d   = 1'b0;
                    error_d  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and synchroniser registers; reset drops the link at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            word_q     <= '0;
            beat_q     <= '0;
            timer_q    <= '0;
            ack_sync_q <= '0;
            send_q     <= 1'b0;
            finish_q   <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            beat_q     <= beat_d;
            timer_q    <= timer_d;
            ack_sync_q <= ack_sync_d;
            send_q     <= send_d;
            finish_q   <= finish_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign dbg_state       = state_q;
    assign link.send       = send_q;
    assign link.finish     = finish_q;
    assign link.data_lanes = data_q;
endmodule
